dino_sprite_render: RTL and testbench
=====================================

Name: dino_sprite_render

Overview:
- Per-pixel renderer for the dino sprite, downstream of the sprite row ROMs (running pose and ducking pose) in the VGA display path.
- Once per line, latches the ROM row for the current vertical count and shifts it out one bit per pixel tick at the dino's horizontal position.
- Picks the pose (run or duck) only at frame boundaries, so a pose change cannot tear the image mid-frame.
- Produces a registered dino pixel and a sticky dino/obstacle collision flag for the game controller.

Parameters:
- X_POS, 64: first screen column of the sprite; legal range is 1..H_VIS-WIDTH.
- WIDTH, 50: sprite row width in bits, MSB = leftmost pixel.
- H_VIS, 640: visible pixels per line.
- Y_RUN, 356: first screen line of the running sprite.
- ROWS_RUN, 47: row count of the running sprite.
- Y_DUCK, 374: first screen line of the ducking sprite.
- ROWS_DUCK, 29: row count of the ducking sprite.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- pix_en  in  1  pixel-rate enable; all state below advances only when pix_en=1
- hc  in  11  horizontal counter from the sync generator
- vc  in  11  vertical counter from the sync generator
- duck_req  in  1  player duck request (level)
- row_run  in  WIDTH  combinational row from the running ROM, addressed by vc
- row_duck  in  WIDTH  combinational row from the ducking ROM, addressed by vc
- obs_pix  in  1  obstacle pixel, aligned with dino_pix (same latency)
- collide_clr  in  1  clears collide
- dino_pix  out  1  sprite pixel, registered
- dino_active  out  1  high while the sprite window is being output
- pose_duck  out  1  pose currently being drawn
- collide  out  1  sticky collision flag

Behaviour:
- Reset: one clock, asynchronous active-high reset (rst), applied to all state at any time.
  - Reset values: dino_pix=0, dino_active=0, pose_duck=0, collide=0, shift register=0, column counter=0.
  - Reset mid-line: outputs stay 0 until the next row-load tick.
- Pose register: on pix_en with hc==0 and vc==0, pose_duck <= duck_req. pose_duck holds at all other times.
- Row load, on pix_en with hc==X_POS-1:
  - If pose_duck=1 and Y_DUCK <= vc < Y_DUCK+ROWS_DUCK: shreg <= row_duck.
  - Else if pose_duck=0 and Y_RUN <= vc < Y_RUN+ROWS_RUN: shreg <= row_run.
  - Otherwise shreg <= 0. ROM outputs are undefined outside their row range and must never be used there.
  - In every case the column counter is set to WIDTH.
- Shift, on pix_en with counter != 0:
  - dino_pix <= shreg[WIDTH-1]; shreg <= shreg<<1; counter decrements by 1; dino_active <= 1.
- Idle, on pix_en with counter == 0 and no load: dino_pix <= 0, dino_active <= 0.
- Latency: the pixel for column X_POS+k appears on dino_pix after the pix_en tick where hc==X_POS+k. That is one pixel of latency, which downstream compensates.
- dino_active is high for exactly WIDTH pix_en ticks per line, including lines with no sprite row.
- Load and shift never coincide, because the counter reaches 0 before hc wraps. If they did coincide, load would win.
- Collision:
  - On pix_en with dino_pix=1 and obs_pix=1, collide <= 1.
  - collide_clr=1 clears it; if a set and a clear occur in the same cycle, set wins.
  - collide stays set across frames until cleared.
- pix_en=0: all registers hold.

Optional Feature:
- Macro: DINO_COLLIDE_EN.
- Defined: collision logic exactly as described above.
- Undefined: no collision flop is built; collide is tied to 0; obs_pix and collide_clr are ignored.

Test Plan:
- Reset: rst pulsed mid-line at hc=80 -> all outputs 0 immediately; resumes normally at the next hc=63 tick.
- Duck single pixel: duck_req=1 across the vc=0,hc=0 tick; frame runs to vc=381 (duck row 7) -> dino_pix=1 only for column 67 (after tick hc=67); dino_active high for hc ticks 64..113.
- Duck wide row: vc=383 (row 9) -> dino_pix high for columns 67..71, 78..91, 95..110; low elsewhere.
- Out of range: vc=373 and vc=403 with pose_duck=1 and row_duck forced to all-ones -> dino_pix stays 0; dino_active still high for 50 ticks.
- Pose tearing: duck_req toggled at vc=380 -> pose_duck unchanged until the next vc=0,hc=0 tick.
- Collision (DINO_COLLIDE_EN): obs_pix=1 at column 67, vc=381 -> collide=1 one clock later and held. collide_clr and a new hit in the same cycle -> collide stays 1. Without the macro -> collide=0 throughout.

Source files
------------

// File: rtl/dino_sprite_render.sv
// Per-pixel dino sprite renderer: latches one ROM row per line and shifts it out at X_POS.
// Define DINO_COLLIDE_EN to build the sticky dino/obstacle collision flag; otherwise collide is tied low.
module dino_sprite_render #(
    parameter int X_POS     = 64,
    parameter int WIDTH     = 50,
    parameter int H_VIS     = 640,
    parameter int Y_RUN     = 356,
    parameter int ROWS_RUN  = 47,
    parameter int Y_DUCK    = 374,
    parameter int ROWS_DUCK = 29
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_en,
    input  logic [10:0]      hc,
    input  logic [10:0]      vc,
    input  logic             duck_req,
    input  logic [WIDTH-1:0] row_run,
    input  logic [WIDTH-1:0] row_duck,
    input  logic             obs_pix,
    input  logic             collide_clr,
    output logic             dino_pix,
    output logic             dino_active,
    output logic             pose_duck,
    output logic             collide
);

    localparam int              CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   CNT_FULL = CW'(WIDTH);
    localparam logic [10:0]     HC_LOAD  = 11'(X_POS - 1);
    localparam logic [10:0]     RUN_LO   = 11'(Y_RUN);
    localparam logic [10:0]     RUN_HI   = 11'(Y_RUN + ROWS_RUN);
    localparam logic [10:0]     DUCK_LO  = 11'(Y_DUCK);
    localparam logic [10:0]     DUCK_HI  = 11'(Y_DUCK + ROWS_DUCK);

    if (X_POS < 1 || X_POS > H_VIS - WIDTH) begin : g_badXPos
        $error("dino_sprite_render: X_POS outside 1..H_VIS-WIDTH");
    end

    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_colCnt;
    logic             r_dinoPix;
    logic             r_dinoActive;
    logic             r_poseDuck;

    logic             w_load;
    logic             w_inRun;
    logic             w_inDuck;
    logic [WIDTH-1:0] w_row;

    assign w_load   = pix_en && (hc == HC_LOAD);
    assign w_inRun  = (vc >= RUN_LO) && (vc < RUN_HI);
    assign w_inDuck = (vc >= DUCK_LO) && (vc < DUCK_HI);

    // ROM rows are garbage outside their own line range, so gate them before they reach the shifter.
    always_comb begin
        w_row = '0;
        if (r_poseDuck && w_inDuck) begin
            w_row = row_duck;
        end else if (!r_poseDuck && w_inRun) begin
            w_row = row_run;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg      <= '0;
            r_colCnt     <= '0;
            r_dinoPix    <= 1'b0;
            r_dinoActive <= 1'b0;
            r_poseDuck   <= 1'b0;
        end else if (pix_en) begin
            if (hc == '0 && vc == '0) begin
                r_poseDuck <= duck_req;
            end
            if (w_load) begin
                r_shreg      <= w_row;
                r_colCnt     <= CNT_FULL;
                r_dinoPix    <= 1'b0;
                r_dinoActive <= 1'b0;
            end else if (r_colCnt != '0) begin
                r_dinoPix    <= r_shreg[WIDTH-1];
                r_shreg      <= {r_shreg[WIDTH-2:0], 1'b0};
                r_colCnt     <= r_colCnt - 1'b1;
                r_dinoActive <= 1'b1;
            end else begin
                r_dinoPix    <= 1'b0;
                r_dinoActive <= 1'b0;
            end
        end
    end

    assign dino_pix    = r_dinoPix;
    assign dino_active = r_dinoActive;
    assign pose_duck   = r_poseDuck;

`ifdef DINO_COLLIDE_EN
    logic r_collide;

    // A hit outranks a simultaneous clear so a collision is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_collide <= 1'b0;
        end else if (pix_en) begin
            if (r_dinoPix && obs_pix) begin
                r_collide <= 1'b1;
            end else if (collide_clr) begin
                r_collide <= 1'b0;
            end
        end
    end

    assign collide = r_collide;
`else
    logic w_unusedCollide;

    assign w_unusedCollide = obs_pix ^ collide_clr;
    assign collide         = 1'b0;
`endif

endmodule

// File: tb/tb_dino_sprite_render.sv
// Scoreboard bench for dino_sprite_render: a reference model pushes expected outputs per tick.
// Collision expectations follow DINO_COLLIDE_EN the same way the design does.
module tb_dino_sprite_render;

    localparam int XP        = 64;
    localparam int W         = 50;
    localparam int Y_RUN     = 356;
    localparam int ROWS_RUN  = 47;
    localparam int Y_DUCK    = 374;
    localparam int ROWS_DUCK = 29;

    typedef struct packed {
        logic pix;
        logic active;
        logic pose;
        logic coll;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         pix_en;
    logic [10:0]  hc;
    logic [10:0]  vc;
    logic         duck_req;
    logic [W-1:0] rowRun;
    logic [W-1:0] rowDuck;
    logic         obs_pix;
    logic         collide_clr;
    logic         dino_pix;
    logic         dino_active;
    logic         pose_duck;
    logic         collide;

    int checks   = 0;
    int failures = 0;

    exp_t         sb[$];
    logic [W-1:0] mRow   = '0;
    logic         mValid = 1'b0;
    logic         mPix   = 1'b0;
    logic         mAct   = 1'b0;
    logic         mPose  = 1'b0;
    logic         mColl  = 1'b0;

    dino_sprite_render dut (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .hc          (hc),
        .vc          (vc),
        .duck_req    (duck_req),
        .row_run     (rowRun),
        .row_duck    (rowDuck),
        .obs_pix     (obs_pix),
        .collide_clr (collide_clr),
        .dino_pix    (dino_pix),
        .dino_active (dino_active),
        .pose_duck   (pose_duck),
        .collide     (collide)
    );

    always #5 clk = ~clk;

    // Drives one clock of stimulus, predicts the registered outputs and queues the prediction.
    task automatic driveTick(input int h, input int v, input logic en, input logic ob, input logic cl);
        exp_t e;
        logic inRange;
        logic newPix;
        logic newAct;
        hc          = 11'(h);
        vc          = 11'(v);
        pix_en      = en;
        obs_pix     = ob;
        collide_clr = cl;
        if (en) begin
            if (h == 0 && v == 0) mPose = duck_req;
            if (h == XP - 1) begin
                inRange = mPose ? (v >= Y_DUCK && v < Y_DUCK + ROWS_DUCK)
                                : (v >= Y_RUN && v < Y_RUN + ROWS_RUN);
                mRow   = inRange ? (mPose ? rowDuck : rowRun) : '0;
                mValid = 1'b1;
            end
            newPix = 1'b0;
            newAct = 1'b0;
            if (mValid && h >= XP && h < XP + W) begin
                newPix = mRow[W-1-(h-XP)];
                newAct = 1'b1;
            end
`ifdef DINO_COLLIDE_EN
            if (mPix && ob) mColl = 1'b1;
            else if (cl) mColl = 1'b0;
`endif
            mPix = newPix;
            mAct = newAct;
        end
        e.pix    = mPix;
        e.active = mAct;
        e.pose   = mPose;
        e.coll   = mColl;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [3:0] got;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({dino_pix, dino_active, pose_duck, collide} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_init got=%b exp=0000", {dino_pix, dino_active, pose_duck, collide});
        end
        rst = 1'b0;
        rowRun = W'({$urandom, $urandom}) | (W'(1) << (W - 1 - 10));
        for (int h = 0; h <= 80; h++) begin
            driveTick(h, 360, 1'b1, 1'b0, 1'b0);
            e = sb.pop_front();
            got = {dino_pix, dino_active, pose_duck, collide};
            checks++;
            if (got !== e) begin
                failures++;
                $display("[TB] FAIL reset_pre h=%0d got=%b exp=%b", h, got, e);
            end
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({dino_pix, dino_active, pose_duck, collide} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_mid got=%b exp=0000", {dino_pix, dino_active, pose_duck, collide});
        end
        rst = 1'b0;
        mValid = 1'b0; mPix = 1'b0; mAct = 1'b0; mPose = 1'b0; mColl = 1'b0;
        for (int h = 81; h <= 130; h++) begin
            driveTick(h, 360, 1'b1, 1'b0, 1'b0);
            e = sb.pop_front();
            got = {dino_pix, dino_active, pose_duck, collide};
            checks++;
            if (got !== e) begin
                failures++;
                $display("[TB] FAIL reset_post h=%0d got=%b exp=%b", h, got, e);
            end
        end
        rowRun = W'({$urandom, $urandom});
        for (int h = 0; h <= 130; h++) begin
            driveTick(h, 361, 1'b1, 1'b0, 1'b0);
            e = sb.pop_front();
            got = {dino_pix, dino_active, pose_duck, collide};
            checks++;
            if (got !== e) begin
                failures++;
                $display("[TB] FAIL reset_resume h=%0d got=%b exp=%b", h, got, e);
            end
        end
    endtask

    task automatic test_hold();
        exp_t e;
        logic [3:0] got;
        rowRun = W'({$urandom, $urandom});
        for (int h = 0; h <= 120; h++) begin
            driveTick(h, 370, 1'b1, 1'b0, 1'b0);
            e = sb.pop_front();
            got = {dino_pix, dino_active, pose_duck, collide};
            checks++;
            if (got !== e) begin
                failures++;
                $display("[TB] FAIL hold_run h=%0d got=%b exp=%b", h, got, e);
            end
            driveTick(h, 0, 1'b0, 1'b0, 1'b0);
            e = sb.pop_front();
            got = {dino_pix, dino_active, pose_duck, collide};
            checks++;
            if (got !== e) begin
                failures++;
                $display("[TB] FAIL hold_gap h=%0d got=%b exp=%b", h, got, e);
            end
        end
    endtask

    task automatic test_duck_single();
        exp_t e;
        logic [3:0] got;
        duck_req = 1'b1;
        driveTick(0, 0, 1'b1, 1'b0, 1'b0);
        e = sb.pop_front();
        got = {dino_pix, dino_active, pose_duck, collide};
        checks++;
        if (got !== e) begin
            failures++;
            $display("[TB] FAIL duck_pose got=%b exp=%b", got, e);
        end
        rowRun  = '1;
        rowDuck = W'(1) << (W - 1 - 3);
        for (int h = 0; h <= 130; h++) begin
            driveTick(h, 381, 1'b1, 1'b0, 1'b0);
            e = sb.pop_front();
            got = {dino_pix, dino_active, pose_duck, collide};
            checks++;
            if (got !== e) begin
                failures++;
                $display("[TB] FAIL duck_single h=%0d got=%b exp=%b", h, got, e);
            end
        end
    endtask

    task automatic test_duck_wide();
        exp_t e;
        logic [3:0] got;
        rowDuck = '0;
        for (int c = XP; c < XP + W; c++) begin
            if ((c >= 67 && c <= 71) || (c >= 78 && c <= 91) || (c >= 95 && c <= 110))
                rowDuck[W-1-(c-XP)] = 1'b1;
        end
        for (int h = 0; h <= 130; h++) begin
            driveTick(h, 383, 1'b1, 1'b0, 1'b0);
            e = sb.pop_front();
            got = {dino_pix, dino_active, pose_duck, collide};
            checks++;
            if (got !== e) begin
                failures++;
                $display("[TB] FAIL duck_wide h=%0d got=%b exp=%b", h, got, e);
            end
        end
    endtask

    task automatic test_out_of_range();
        exp_t e;
        logic [3:0] got;
        int lines[2] = '{373, 403};
        rowDuck = '1;
        rowRun  = '1;
        foreach (lines[i]) begin
            for (int h = 0; h <= 130; h++) begin
                driveTick(h, lines[i], 1'b1, 1'b0, 1'b0);
                e = sb.pop_front();
                got = {dino_pix, dino_active, pose_duck, collide};
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("[TB] FAIL out_of_range vc=%0d h=%0d got=%b exp=%b", lines[i], h, got, e);
                end
            end
        end
    endtask

    task automatic test_pose_tearing();
        exp_t e;
        logic [3:0] got;
        duck_req = 1'b0;
        rowDuck  = W'({$urandom, $urandom});
        for (int h = 0; h <= 130; h++) begin
            driveTick(h, 380, 1'b1, 1'b0, 1'b0);
            e = sb.pop_front();
            got = {dino_pix, dino_active, pose_duck, collide};
            checks++;
            if (got !== e) begin
                failures++;
                $display("[TB] FAIL tear_hold h=%0d got=%b exp=%b", h, got, e);
            end
        end
        driveTick(0, 0, 1'b1, 1'b0, 1'b0);
        e = sb.pop_front();
        got = {dino_pix, dino_active, pose_duck, collide};
        checks++;
        if (got !== e) begin
            failures++;
            $display("[TB] FAIL tear_frame got=%b exp=%b", got, e);
        end
        rowDuck = '1;
        rowRun  = W'({$urandom, $urandom});
        for (int h = 0; h <= 130; h++) begin
            driveTick(h, 381, 1'b1, 1'b0, 1'b0);
            e = sb.pop_front();
            got = {dino_pix, dino_active, pose_duck, collide};
            checks++;
            if (got !== e) begin
                failures++;
                $display("[TB] FAIL tear_run h=%0d got=%b exp=%b", h, got, e);
            end
        end
    endtask

    task automatic test_collision();
        exp_t e;
        logic [3:0] got;
        duck_req = 1'b1;
        driveTick(0, 0, 1'b1, 1'b0, 1'b0);
        void'(sb.pop_front());
        rowDuck = W'(1) << (W - 1 - 3);
        rowRun  = '1;
        for (int h = 0; h <= 130; h++) begin
            driveTick(h, 381, 1'b1, (h == 66 || h == 68), 1'b0);
            e = sb.pop_front();
            got = {dino_pix, dino_active, pose_duck, collide};
            checks++;
            if (got !== e) begin
                failures++;
                $display("[TB] FAIL collide_hit h=%0d got=%b exp=%b", h, got, e);
            end
        end
        for (int h = 0; h <= 130; h++) begin
            driveTick(h, 381, 1'b1, (h == 68), (h == 10 || h == 68 || h == 120));
            e = sb.pop_front();
            got = {dino_pix, dino_active, pose_duck, collide};
            checks++;
            if (got !== e) begin
                failures++;
                $display("[TB] FAIL collide_clr h=%0d got=%b exp=%b", h, got, e);
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        pix_en      = 1'b0;
        hc          = '0;
        vc          = 11'd500;
        duck_req    = 1'b0;
        rowRun      = '0;
        rowDuck     = '0;
        obs_pix     = 1'b0;
        collide_clr = 1'b0;
        test_reset();
        test_hold();
        test_duck_single();
        test_duck_wide();
        test_out_of_range();
        test_pose_tearing();
        test_collision();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
